// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU result capture path
package fpu_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  status;
    logic        flag;
  } res_entry_t;
  localparam int RES_FIFO_DEPTH = 8;
endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: synchronous FIFO of result entries with valid/ready read side
module fpu_res_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = RES_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clock100KHz,
  input  logic          reset,
  input  logic          wr_en,
  input  res_entry_t    wr_entry,
  input  logic          rd_ready,
  output logic          rd_valid,
  output res_entry_t    rd_entry,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          wr_drop
);
  res_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, push;
  assign rd_valid = level != '0;
  assign full     = level == LW'(DEPTH);
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push     = wr_en & (~full | pop);
  assign wr_drop  = wr_en & ~push;
  assign rd_entry = mem[rd_ptr];
  always_ff @(posedge clock100KHz)
    if (push) mem[wr_ptr] <= wr_entry;
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= push && !pop ? level + 1'b1 : pop && !push ? level - 1'b1 : level;
    end
  end
endmodule

// File: rtl/fpu_result_capture.sv
// fpu_result_capture: captures each changed FPU result tuple into a FIFO
module fpu_result_capture
  import fpu_pkg::*;
#(
  parameter int DEPTH = RES_FIFO_DEPTH
) (
  input  logic                     clock100KHz,
  input  logic                     reset,
  input  logic [31:0]              data_in,
  input  logic [3:0]               status_in,
  input  logic                     flag_in,
  input  logic                     capture_en,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [3:0]               rd_status,
  output logic                     rd_flag,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [7:0]               drop_count
);
  res_entry_t cur, last_q, head;
  logic is_new, wr_drop;
  assign cur    = '{data: data_in, status: status_in, flag: flag_in};
  assign is_new = cur != last_q;
  assign rd_data   = head.data;
  assign rd_status = head.status;
  assign rd_flag   = head.flag;
  fpu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock100KHz(clock100KHz),
    .reset      (reset),
    .wr_en      (is_new & capture_en),
    .wr_entry   (cur),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_entry   (head),
    .level      (level),
    .full       (full),
    .wr_drop    (wr_drop)
  );
  // Last sample updates regardless of capture_en so masked changes are never replayed
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      last_q     <= '0;
      drop_count <= '0;
    end else begin
      last_q <= cur;
      if (wr_drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_result_capture.sv
// tb_fpu_result_capture: directed scoreboard bench for fpu_result_capture
module tb_fpu_result_capture;
  import fpu_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic reset, flag_in, capture_en, rd_ready;
  logic [31:0] data_in;
  logic [3:0] status_in;
  logic rd_valid, rd_flag, full;
  logic [31:0] rd_data;
  logic [3:0] rd_status;
  logic [3:0] level;
  logic [7:0] drop_count;
  int checks = 0, errors = 0;
  res_entry_t q[$];
  res_entry_t last_m;
  int drops_m;
  always #5 clk = ~clk;
  fpu_result_capture #(.DEPTH(DEPTH)) dut (
    .clock100KHz(clk), .reset(reset), .data_in(data_in), .status_in(status_in),
    .flag_in(flag_in), .capture_en(capture_en), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_status(rd_status), .rd_flag(rd_flag),
    .level(level), .full(full), .drop_count(drop_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] d, input logic [3:0] s, input logic f);
    data_in = d;
    status_in = s;
    flag_in = f;
  endtask
  task automatic cycle();
    res_entry_t cur;
    logic pop, push, drop;
    #2;
    cur = '{data: data_in, status: status_in, flag: flag_in};
    pop = rd_ready && q.size() > 0;
    if (pop) begin
      chk("pop_data", rd_data, q[0].data);
      chk("pop_status", {28'd0, rd_status}, {28'd0, q[0].status});
      chk("pop_flag", {31'd0, rd_flag}, {31'd0, q[0].flag});
    end
    push = !reset && capture_en && cur != last_m;
    drop = push && q.size() == DEPTH && !pop;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      last_m = '0;
      drops_m = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(cur);
      if (drop && drops_m < 255) drops_m++;
      last_m = cur;
    end
    chk("level", {28'd0, level}, q.size());
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, q.size() != 0});
    chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
    chk("drop_count", {24'd0, drop_count}, drops_m);
  endtask
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    reset = 1; capture_en = 0; rd_ready = 0; drive(0, 0, 0);
    last_m = '0; drops_m = 0;
    cycles(2);
    reset = 0;
    chk("reset_level", {28'd0, level}, 0);
    chk("reset_valid", {31'd0, rd_valid}, 0);
    chk("reset_full", {31'd0, full}, 0);
    chk("reset_drop", {24'd0, drop_count}, 0);
    // held tuple pushes once
    capture_en = 1; drive(32'h3F800000, 4'b0001, 0);
    cycles(5);
    chk("hold_level", {28'd0, level}, 1);
    chk("hold_data", rd_data, 32'h3F800000);
    chk("hold_status", {28'd0, rd_status}, 1);
    rd_ready = 1; cycle(); rd_ready = 0;
    // push into empty with rd_ready: pop ignored
    drive(32'h12345678, 4'hA, 1); rd_ready = 1; cycle();
    chk("empty_pushpop_level", {28'd0, level}, 1);
    cycle(); rd_ready = 0;
    chk("empty_drained", {28'd0, level}, 0);
    // fill past full
    for (int i = 1; i <= 9; i++) begin
      drive(32'h100 + i, 4'(i), i[0]);
      cycle();
    end
    chk("fill_level", {28'd0, level}, 8);
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_drop", {24'd0, drop_count}, 1);
    chk("fill_head", rd_data, 32'h101);
    // push and pop while full
    drive(32'hABCD0000, 4'h5, 1); rd_ready = 1; cycle();
    chk("fullpp_level", {28'd0, level}, 8);
    chk("fullpp_drop", {24'd0, drop_count}, 1);
    cycles(8);
    rd_ready = 0;
    chk("drained", {28'd0, level}, 0);
    // change while capture disabled is never pushed
    capture_en = 0; drive(32'h40000000, 0, 0); cycle();
    capture_en = 1; cycles(3);
    chk("masked_level", {28'd0, level}, 0);
    // reset with entries, then unchanged nonzero tuple captured once
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + i, 4'h3, 0);
      cycle();
    end
    chk("pre_reset_level", {28'd0, level}, 3);
    reset = 1; cycle(); reset = 0;
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    cycles(3);
    chk("post_reset_level", {28'd0, level}, 1);
    chk("post_reset_data", rd_data, 32'h202);
    // drop counter saturation
    for (int i = 0; i < 270; i++) begin
      drive(32'h1000 + i, 4'h0, 0);
      cycle();
    end
    chk("drop_sat", {24'd0, drop_count}, 255);
    rd_ready = 1; cycles(9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
